tft_init_sequencer: RTL and testbench

TFT_INIT_SEQUENCER -- requirements
Module: tft_init_sequencer

---
 rtl/tft_init_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_tft_init_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/tft_init_sequencer.sv
// TFT panel bring-up sequencer: drives the panel reset, replays a fixed command ROM
// through a byte-wide SPI engine, then forwards user bytes once the panel is initialised.
module tft_init_sequencer #(
   parameter int unsigned RST_LOW_CYC  = 16,
   parameter int unsigned RST_WAIT_CYC = 64,
   parameter int unsigned DLY_UNIT_CYC = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       init_start,
   input  logic       spi_ready,
   output logic       spi_start,
   output logic [7:0] spi_data,
   output logic       spi_dc,
   output logic       lcd_reset_n,
   output logic       busy,
   output logic       init_done,
   input  logic       usr_valid,
   input  logic [7:0] usr_data,
   input  logic       usr_dc,
   output logic       usr_ready
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_RST_LOW,
      S_RST_WAIT,
      S_FETCH,
      S_SEND,
      S_WAIT_ACK,
      S_WAIT_DONE,
      S_DELAY,
      S_READY
   } state_t;

   localparam logic [1:0] T_CMD  = 2'd0;
   localparam logic [1:0] T_DATA = 2'd1;
   localparam logic [1:0] T_DLY  = 2'd2;
   localparam logic [1:0] T_END  = 2'd3;

   // Entry format {type[1:0], val[7:0]}; unused slots are END.
   function automatic logic [9:0] rom_entry(input logic [3:0] idx);
      logic [9:0] e;
      case (idx)
         4'd0:    e = {T_CMD,  8'h01};
         4'd1:    e = {T_DLY,  8'd150};
         4'd2:    e = {T_CMD,  8'h11};
         4'd3:    e = {T_DLY,  8'd255};
         4'd4:    e = {T_CMD,  8'h3A};
         4'd5:    e = {T_DATA, 8'h05};
         4'd6:    e = {T_CMD,  8'h36};
         4'd7:    e = {T_DATA, 8'hC8};
         4'd8:    e = {T_CMD,  8'h29};
         4'd9:    e = {T_DLY,  8'd100};
         default: e = {T_END,  8'h00};
      endcase
      return e;
   endfunction

   function automatic logic [3:0] idx_sat_inc(input logic [3:0] idx);
      return (idx == 4'd15) ? idx : idx + 4'd1;
   endfunction

   state_t      state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic [31:0] cnt_q, cnt_d;
   logic [7:0]  data_q, data_d;
   logic        dc_q, dc_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        usr_q, usr_d;

   logic [9:0]  entry;
   logic [1:0]  ent_type;
   logic [7:0]  ent_val;
   logic [31:0] dly_prod;
   logic        launch;
   logic [7:0]  launch_data;
   logic        launch_dc;
   logic        usr_acc;

   assign entry    = rom_entry(idx_q);
   assign ent_type = entry[9:8];
   assign ent_val  = entry[7:0];
   // 255 * DLY_UNIT_CYC must fit in 32 bits, so widen val before multiplying.
   assign dly_prod = {24'd0, ent_val} * DLY_UNIT_CYC;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= 4'd0;
         cnt_q   <= 32'd0;
         data_q  <= 8'h00;
         dc_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         usr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         dc_q    <= dc_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         usr_q   <= usr_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      data_d      = data_q;
      dc_d        = dc_q;
      busy_d      = busy_q;
      done_d      = done_q;
      usr_d       = usr_q;
      launch      = 1'b0;
      launch_data = data_q;
      launch_dc   = dc_q;
      usr_acc     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (init_start) begin
               state_d = S_RST_LOW;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               idx_d   = 4'd0;
               cnt_d   = RST_LOW_CYC;
            end
         end
         S_RST_LOW: begin
            if (cnt_q <= 32'd1) begin
               state_d = S_RST_WAIT;
               cnt_d   = RST_WAIT_CYC;
            end else begin
               cnt_d = cnt_q - 32'd1;
            end
         end
         S_RST_WAIT: begin
            if (cnt_q <= 32'd1) begin
               state_d = S_FETCH;
               cnt_d   = 32'd0;
            end else begin
               cnt_d = cnt_q - 32'd1;
            end
         end
         S_FETCH: begin
            // The last slot doubles as a terminator so a ROM without END still finishes.
            if (ent_type == T_END || idx_q == 4'd15) begin
               state_d = S_READY;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else if (ent_type == T_DLY) begin
               state_d = S_DELAY;
               cnt_d   = dly_prod;
            end else begin
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            if (spi_ready) begin
               launch      = 1'b1;
               launch_data = ent_val;
               launch_dc   = ent_type[0];
               data_d      = ent_val;
               dc_d        = ent_type[0];
               usr_d       = 1'b0;
               state_d     = S_WAIT_ACK;
            end
         end
         S_WAIT_ACK: begin
            if (!spi_ready) state_d = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            if (spi_ready) begin
               if (usr_q) begin
                  state_d = S_READY;
               end else begin
                  idx_d   = idx_sat_inc(idx_q);
                  state_d = S_FETCH;
               end
            end
         end
         S_DELAY: begin
            // A zero-length delay still spends its single cycle here.
            if (cnt_q <= 32'd1) begin
               cnt_d   = 32'd0;
               idx_d   = idx_sat_inc(idx_q);
               state_d = S_FETCH;
            end else begin
               cnt_d = cnt_q - 32'd1;
            end
         end
         S_READY: begin
            if (init_start) begin
               state_d = S_RST_LOW;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               idx_d   = 4'd0;
               cnt_d   = RST_LOW_CYC;
            end else if (usr_valid && spi_ready) begin
               usr_acc     = 1'b1;
               launch      = 1'b1;
               launch_data = usr_data;
               launch_dc   = usr_dc;
               data_d      = usr_data;
               dc_d        = usr_dc;
               usr_d       = 1'b1;
               state_d     = S_WAIT_ACK;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign spi_start   = launch;
   assign spi_data    = launch_data;
   assign spi_dc      = launch_dc;
   assign usr_ready   = usr_acc;
   // Panel stays in reset from power-up until the first sequence leaves RST_LOW.
   assign lcd_reset_n = !(state_q == S_IDLE || state_q == S_RST_LOW);
   assign busy        = busy_q;
   assign init_done   = done_q;

endmodule

// File: tb/tb_tft_init_sequencer.sv
// Randomized bench for tft_init_sequencer: an SPI engine model plus a ROM-walking
// timing model predicts every launched byte, its cycle, and the user-path handshake.
module tb_tft_init_sequencer;

   localparam int U  = 2;
   localparam int RL = 4;
   localparam int RW = 8;

   logic       clk = 1'b0;
   logic       rst_n, init_start, spi_ready, usr_valid, usr_dc;
   logic [7:0] usr_data;
   logic       spi_start, spi_dc, lcd_reset_n, busy, init_done, usr_ready;
   logic [7:0] spi_data;

   tft_init_sequencer #(
      .RST_LOW_CYC (RL),
      .RST_WAIT_CYC(RW),
      .DLY_UNIT_CYC(U)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .init_start (init_start),
      .spi_ready  (spi_ready),
      .spi_start  (spi_start),
      .spi_data   (spi_data),
      .spi_dc     (spi_dc),
      .lcd_reset_n(lcd_reset_n),
      .busy       (busy),
      .init_done  (init_done),
      .usr_valid  (usr_valid),
      .usr_data   (usr_data),
      .usr_dc     (usr_dc),
      .usr_ready  (usr_ready)
   );

   always #5 clk = ~clk;

   int rom_t[16];
   int rom_v[16];

   int cyc, spi_cnt, busy_len, long_idx;
   bit rand_busy;
   int lc_q[$];
   int lb_q[$];
   logic [7:0] ld_q[$];
   logic ldc_q[$];
   int done_cyc, lcd_rise_cyc, lcd_fall_cyc, busy_rise_cyc, inflight_err, uready_cnt;
   logic done_flag, p_lcd, p_busy;
   int n_chk, n_pass;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
   endtask

   // One clock cycle: inputs change at the falling edge, outputs sampled 1ns later.
   task automatic tick(input logic r, input logic ini, input logic uv, input logic [7:0] ud,
                       input logic udc);
      int b;
      @(negedge clk);
      cyc++;
      rst_n = r; init_start = ini; usr_valid = uv; usr_data = ud; usr_dc = udc;
      if (spi_cnt > 0) begin
         spi_ready = 1'b0;
         spi_cnt--;
      end else begin
         spi_ready = 1'b1;
      end
      #1;
      if (spi_start === 1'b1) begin
         if (!spi_ready) inflight_err++;
         if (lc_q.size() == long_idx) b = 100;
         else if (rand_busy) b = int'($urandom_range(3, 12));
         else b = busy_len;
         lc_q.push_back(cyc); lb_q.push_back(b); ld_q.push_back(spi_data); ldc_q.push_back(spi_dc);
         spi_cnt = b;
      end
      if (usr_ready === 1'b1) uready_cnt++;
      if (!p_lcd && lcd_reset_n) lcd_rise_cyc = cyc;
      if (p_lcd && !lcd_reset_n) lcd_fall_cyc = cyc;
      if (!p_busy && busy) busy_rise_cyc = cyc;
      if (p_busy && !busy) begin
         done_cyc  = cyc;
         done_flag = init_done;
      end
      p_lcd = lcd_reset_n; p_busy = busy;
   endtask

   task automatic idle_tick();
      tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic check_reset_vals(input string tag);
      check_val(tag, {spi_start, spi_data, spi_dc, lcd_reset_n, busy, init_done, usr_ready}, 32'd0);
   endtask

   // Walk the ROM: a byte launches B+3 cycles after the previous one, each delay entry of
   // D cycles (minimum 1) adds D+1, the sequence starts RL+RW+2 cycles after init_start,
   // and busy falls when the END entry would have been "launched".
   task automatic verify_init(input string tag, input int c, input int base, input int nbytes);
      int t, j, d;
      bit stop;
      t = c + RL + RW + 2; j = base; stop = 1'b0;
      for (int e = 0; e < 16 && !stop; e++) begin
         if (e == 15 || rom_t[e] == 3) begin
            if (nbytes < 0) begin
               check_val({tag, " done_cyc"}, done_cyc, t);
               check_val({tag, " init_done"}, 32'(done_flag), 32'd1);
               check_val({tag, " byte_count"}, lc_q.size() - base, j - base);
            end
            stop = 1'b1;
         end else if (rom_t[e] == 2) begin
            d = rom_v[e] * U;
            if (d == 0) d = 1;
            t += d + 1;
         end else if (nbytes >= 0 && j - base >= nbytes) begin
            stop = 1'b1;
         end else if (j >= lc_q.size()) begin
            check_val({tag, " launches_seen"}, lc_q.size(), j + 1);
            stop = 1'b1;
         end else begin
            check_val({tag, " launch_cyc"}, lc_q[j], t);
            check_val({tag, " data"}, ld_q[j], rom_v[e]);
            check_val({tag, " dc"}, 32'(ldc_q[j]), rom_t[e] & 1);
            t = lc_q[j] + lb_q[j] + 3;
            j++;
         end
      end
   endtask

   task automatic run_to_done(input int pulse_off);
      for (int i = 1; i < 3000 && done_cyc < 0; i++) tick(1'b1, i == pulse_off, 1'b0, 8'h00, 1'b0);
      check_val("run_timeout", 32'(done_cyc >= 0), 32'd1);
   endtask

   initial begin
      int c, base, next_ok, k;
      logic uv, udc, exp_acc;
      logic [7:0] ud;
      rom_t = '{0, 2, 0, 2, 0, 1, 0, 1, 0, 2, 3, 3, 3, 3, 3, 3};
      rom_v = '{8'h01, 150, 8'h11, 255, 8'h3A, 8'h05, 8'h36, 8'hC8, 8'h29, 100, 0, 0, 0, 0, 0, 0};
      rst_n = 1'b1; init_start = 1'b0; spi_ready = 1'b1; usr_valid = 1'b0; usr_data = 8'h00;
      usr_dc = 1'b0;
      cyc = 0; spi_cnt = 0; busy_len = 10; long_idx = -1; rand_busy = 1'b0;
      done_cyc = -1; lcd_rise_cyc = -1; lcd_fall_cyc = -1; busy_rise_cyc = -1;
      inflight_err = 0; uready_cnt = 0; done_flag = 1'b0; p_lcd = 1'b0; p_busy = 1'b0;
      n_chk = 0; n_pass = 0;

      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      check_reset_vals("reset_outputs");
      for (int i = 0; i < 5; i++) idle_tick();
      check_val("idle_lcd_reset_n", 32'(lcd_reset_n), 32'd0);
      check_val("idle_busy", 32'(busy), 32'd0);
      check_val("idle_usr_ready", 32'(usr_ready), 32'd0);

      // Full run with a stray init_start while busy.
      base = lc_q.size(); done_cyc = -1; c = cyc + 1;
      tick(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
      run_to_done(int'($urandom_range(20, 600)));
      check_val("run1 busy_rise", busy_rise_cyc, c + 1);
      check_val("run1 lcd_rise", lcd_rise_cyc, c + RL + 1);
      verify_init("run1", c, base, -1);
      if (lc_q.size() >= base + 2)
         check_val("run1 gap_after_01_ge_300", 32'(lc_q[base+1] - lc_q[base] >= 300), 32'd1);
      check_val("run1 inflight_start", inflight_err, 0);

      // Held user byte: accepted once, then again only after the engine is idle.
      idle_tick(); idle_tick();
      uready_cnt = 0; base = lc_q.size();
      for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 1'b1, 8'hA5, 1'b1);
      check_val("usr_hold uready_cnt", uready_cnt, 1);
      check_val("usr_hold launches", lc_q.size() - base, 1);
      if (lc_q.size() > base) begin
         check_val("usr_hold data", ld_q[base], 8'hA5);
         check_val("usr_hold dc", 32'(ldc_q[base]), 32'd1);
      end
      for (int i = 0; i < 50 && lc_q.size() < base + 2; i++) tick(1'b1, 1'b0, 1'b1, 8'hA5, 1'b1);
      check_val("usr_hold second_accept", lc_q.size() - base, 2);
      if (lc_q.size() >= base + 2)
         check_val("usr_hold reaccept_gap", lc_q[base+1] - lc_q[base], lb_q[base] + 2);
      check_val("usr_hold uready_cnt2", uready_cnt, 2);

      // Random user traffic with random engine busy times.
      rand_busy = 1'b1;
      next_ok = lc_q[lc_q.size()-1] + lb_q[lb_q.size()-1] + 2;
      for (int i = 0; i < 300; i++) begin
         uv = 1'($urandom_range(0, 1)); ud = 8'($urandom); udc = 1'($urandom_range(0, 1));
         tick(1'b1, 1'b0, uv, ud, udc);
         exp_acc = uv && (cyc >= next_ok);
         check_val("rand usr_ready", 32'(usr_ready), 32'(exp_acc));
         check_val("rand spi_start", 32'(spi_start), 32'(exp_acc));
         if (exp_acc) begin
            check_val("rand data", spi_data, ud);
            check_val("rand dc", 32'(spi_dc), 32'(udc));
            next_ok = cyc + lb_q[lb_q.size()-1] + 2;
         end
      end
      for (int i = 0; i < 200 && cyc + 1 < next_ok; i++) idle_tick();

      // init_start beats a same-cycle usr_valid, then reset lands inside the delay after 11.
      base = lc_q.size(); c = cyc + 1; done_cyc = -1;
      tick(1'b1, 1'b1, 1'b1, 8'h3C, 1'b0);
      check_val("collide usr_ready", 32'(usr_ready), 32'd0);
      check_val("collide spi_start", 32'(spi_start), 32'd0);
      tick(1'b1, 1'b0, 1'b1, 8'h3C, 1'b0);
      check_val("collide lcd_fall", lcd_fall_cyc, c + 1);
      check_val("collide busy", 32'(busy), 32'd1);
      check_val("collide init_done", 32'(init_done), 32'd0);
      for (int i = 0; i < 2000 && lc_q.size() < base + 2; i++) idle_tick();
      for (int i = 0; i < 40; i++) idle_tick();
      check_val("run3 lcd_rise", lcd_rise_cyc, c + RL + 1);
      verify_init("run3", c, base, 2);
      check_val("run3 no_byte_in_delay", lc_q.size() - base, 2);
      k = lc_q.size();
      tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      check_reset_vals("midreset_outputs");
      for (int i = 0; i < 15; i++) tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 3; i++) idle_tick();
      check_val("postreset lcd_reset_n", 32'(lcd_reset_n), 32'd0);
      check_val("postreset no_launch", lc_q.size(), k);

      // Full restart with one transfer stalling the engine for 100 cycles.
      rand_busy = 1'b0; busy_len = 10;
      base = lc_q.size(); long_idx = base + 2; done_cyc = -1; c = cyc + 1;
      tick(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
      run_to_done(-1);
      verify_init("run2", c, base, -1);
      if (lc_q.size() >= base + 4)
         check_val("run2 stall_gap", lc_q[base+3] - lc_q[base+2], 103);
      check_val("run2 inflight_start", inflight_err, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
